// File: rtl/qspi_cmd_ctrl.sv
// qspi_cmd_ctrl: QSPI command decoder (0x02 write / 0x03 read) driving a byte-wide memory port.
// Build option QSPI_CTRL_ADDR_INC_EN: when defined, mem_addr advances after each write ack and
// for each read prefetch; when undefined the address stays fixed for the whole transaction.
module qspi_cmd_ctrl (
    input  logic        clk,
    input  logic        nrst,
    input  logic        ncs_i,
    input  logic [7:0]  cmd_i,
    input  logic        cmd_valid_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        tx_we_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_done_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [23:0] mem_addr_o,
    output logic [7:0]  mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [7:0]  mem_rdata_i,
    output logic        overrun_o
);
`ifdef QSPI_CTRL_ADDR_INC_EN
    localparam logic [23:0] ADDR_STEP = 24'd1;
`else
    localparam logic [23:0] ADDR_STEP = 24'd0;
`endif

    typedef enum logic [2:0] {IDLE, ADDR, WR_DATA, RD_FETCH, RD_SEND, IGNORE} state_t;

    state_t      state_q;
    logic [1:0]  cnt_q;
    logic        wr_q;
    logic        drop_q;
    logic [23:0] addr_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [23:0] mem_addr_q;
    logic [7:0]  mem_wdata_q;
    logic        tx_we_q;
    logic [7:0]  tx_data_q;
    logic        overrun_q;

    logic        busy_d;
    logic        live_ack_d;
    logic [23:0] addr_nxt_d;
    logic [23:0] wr_addr_d;
    logic [23:0] addr_shift_d;

    // busy: a request is still waiting for its ack this cycle; live_ack: an ack whose result we keep
    assign busy_d       = mem_req_q && !mem_ack_i;
    assign live_ack_d   = mem_req_q && mem_ack_i && !drop_q;
    assign addr_nxt_d   = addr_q + ADDR_STEP;
    assign wr_addr_d    = live_ack_d ? addr_nxt_d : addr_q;
    assign addr_shift_d = {addr_q[15:0], rx_data_i};

    // Transaction FSM: decode, address capture, write issue, read fetch/prefetch, abort handling
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            drop_q      <= 1'b0;
            addr_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tx_we_q     <= 1'b0;
            tx_data_q   <= '0;
            overrun_q   <= 1'b0;
        end else begin
            if (mem_req_q && mem_ack_i) begin
                mem_req_q <= 1'b0;
                drop_q    <= 1'b0;
            end
            if (ncs_i) begin
                state_q <= IDLE;
                tx_we_q <= 1'b0;
                if (busy_d) drop_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: if (cmd_valid_i) begin
                        overrun_q <= 1'b0;
                        cnt_q     <= '0;
                        wr_q      <= (cmd_i == 8'h02);
                        state_q   <= (cmd_i == 8'h02 || cmd_i == 8'h03) ? ADDR : IGNORE;
                    end
                    ADDR: if (rx_valid_i) begin
                        addr_q <= addr_shift_d;
                        cnt_q  <= cnt_q + 2'd1;
                        if (!mem_req_q) mem_addr_q <= addr_shift_d;
                        if (cnt_q == 2'd2) begin
                            state_q <= wr_q ? WR_DATA : RD_FETCH;
                            if (!wr_q && !mem_req_q) begin
                                mem_req_q <= 1'b1;
                                mem_we_q  <= 1'b0;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (live_ack_d) addr_q <= addr_nxt_d;
                        if (rx_valid_i && busy_d) overrun_q <= 1'b1;
                        else if (rx_valid_i) begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= wr_addr_d;
                            mem_wdata_q <= rx_data_i;
                        end
                    end
                    RD_FETCH: begin
                        if (live_ack_d) begin
                            tx_data_q <= mem_rdata_i;
                            tx_we_q   <= 1'b1;
                            state_q   <= RD_SEND;
                        end else if (!mem_req_q) begin
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= addr_q;
                        end
                    end
                    RD_SEND: begin
                        if (live_ack_d) tx_data_q <= mem_rdata_i;
                        if (tx_done_i && busy_d) overrun_q <= 1'b1;
                        else if (tx_done_i) begin
                            addr_q     <= addr_nxt_d;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= addr_nxt_d;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign tx_we_o     = tx_we_q;
    assign tx_data_o   = tx_data_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign overrun_o   = overrun_q;
endmodule

// File: doc/qspi_cmd_ctrl.md
QSPI_CMD_CTRL -- requirements
Module: qspi_cmd_ctrl

Interface
REQ-001 Reset is synchronous and active-low; one clock.
REQ-002 clk  in  1  system clock; all inputs are synchronous to it.
REQ-003 nrst  in  1  synchronous active-low reset.
REQ-004 ncs  in  1  QSPI chip select, high = no transaction.
REQ-005 cmd  in  8  command byte from the QSPI slave.
REQ-006 cmd_valid  in  1  one-cycle pulse, cmd valid.
REQ-007 rx_data  in  8  host-to-device data byte.
REQ-008 rx_valid  in  1  one-cycle pulse, rx_data valid.
REQ-009 tx_we  out  1  switches the QSPI slave to device-to-host drive.
REQ-010 tx_data  out  8  byte driven to the host.
REQ-011 tx_done  in  1  one-cycle pulse, tx_data taken by the shifter.
REQ-012 mem_req  out  1  memory request.
REQ-013 mem_we  out  1  1 = write, 0 = read.
REQ-014 mem_addr  out  24  byte address.
REQ-015 mem_wdata  out  8  write data.
REQ-016 mem_ack  in  1  one-cycle completion pulse.
REQ-017 mem_rdata  in  8  read data, valid with mem_ack.
REQ-018 overrun  out  1  sticky error flag.

Function
REQ-019 States SHALL be: IDLE, ADDR, WR_DATA, RD_FETCH, RD_SEND, IGNORE.
REQ-020 IDLE: a cmd_valid with 0x02 goes to ADDR (write), 0x03 goes to ADDR (read), any other value goes to IGNORE; cmd_valid also clears overrun and the byte counter.
REQ-021 cmd_valid outside IDLE SHALL be ignored.
REQ-022 ADDR: three rx_valid bytes SHALL load mem_addr MSB first, [23:16], [15:8], [7:0].
REQ-023 After the 3rd byte, a write goes to WR_DATA; a read goes to RD_FETCH and asserts a mem read on the next cycle.
REQ-024 WR_DATA: each rx_valid SHALL issue mem_req=1, mem_we=1, mem_wdata=rx_data at the current address on the next cycle.
REQ-025 mem_req/mem_we/mem_addr/mem_wdata SHALL be held stable until the cycle mem_ack is seen; mem_req is deasserted the cycle after mem_ack.
REQ-026 rx_valid in WR_DATA while a write is outstanding SHALL be dropped and SHALL set overrun.
REQ-027 RD_FETCH: on mem_ack, tx_data <= mem_rdata, tx_we <= 1, then go to RD_SEND.
REQ-028 tx_we SHALL stay 1 until ncs rises.
REQ-029 RD_SEND: on tx_done, issue a read at the next address (prefetch) and update tx_data on its mem_ack.
REQ-030 tx_done while a prefetch is outstanding SHALL set overrun; tx_data is unchanged.
REQ-031 mem_addr arithmetic is 24-bit modulo: 0xFFFFFF+1 = 0x000000.
REQ-032 IGNORE: no mem_req and no tx_we until ncs rises.
REQ-033 ncs=1 in any state: next state IDLE and tx_we <= 0 the next cycle.
REQ-034 A mem_req outstanding when ncs rises SHALL be held until mem_ack, its result discarded; no new request is issued.
REQ-035 A cmd_valid arriving before that ack SHALL be accepted and serviced after the ack.
REQ-036 Latency: rx_valid to mem_req is 1 cycle; mem_ack to tx_data updated is 1 cycle.

Reset
REQ-037 nrst=0 at a clk edge: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, tx_we=0, tx_data=0, overrun=0.
REQ-038 Reset mid-transfer SHALL abandon any outstanding request without waiting for mem_ack.

Configuration
REQ-039 Macro QSPI_CTRL_ADDR_INC_EN.
REQ-040 Defined: mem_addr increments by 1 after each completed write ack and for each prefetch.
REQ-041 Undefined: mem_addr stays fixed for the whole transaction (FIFO-style port); all other behaviour is identical.

Verification
REQ-042 Write: cmd 0x02, addr 0x00_10_20, data 0xAA,0xBB, ack 2 cycles after each req -> writes 0xAA@0x001020 and 0xBB@0x001021 (fixed 0x001020 without the macro), overrun=0.
REQ-043 Read: cmd 0x03, addr 0x000100, mem returns 0x5A then 0x5B -> tx_we=1, tx_data=0x5A; after tx_done, prefetch@0x000101 -> tx_data=0x5B.
REQ-044 Overrun: write with ack delayed 10 cycles and second rx_valid at 3 cycles -> second byte dropped, overrun=1; next cmd_valid clears it.
REQ-045 Wrap/unknown: write at 0xFFFFFF, 2 bytes -> second byte @0x000000; cmd 0x7E -> no mem_req until ncs, then IDLE.
REQ-046 Abort: ncs rises with a read outstanding, ack 3 cycles later -> tx_we=0 next cycle, mem_req drops after ack, tx_data unchanged; nrst=0 mid-read -> all outputs at reset values next cycle.
